proj_lane: RTL and testbench

- Self-checking traffic lane for FIFO/datapath bring-up.
- A generator pushes an incrementing W-bit count into a synchronous FIFO of depth D.
- A throttled checker pops the FIFO, compares each word against its own expected count, and accumulates mismatches in a saturating error counter.
- Used as a stand-alone integrity lane in project-level tests. All logic runs on one clock.

---
 rtl/proj_lane.sv | 78 +++++++
 tb/tb_proj_lane.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/proj_lane.sv
// Self-checking traffic lane: counter generator -> FWFT FIFO -> throttled checker.
// Optional PROJ_LANE_ERRINJ_EN adds an errinj input that flips bit 0 of a written word.
module proj_lane #(
  parameter int unsigned W    = 16,
  parameter int unsigned EW   = 8,
  parameter int unsigned D    = 8,
  parameter int          EDBG = 0,
  parameter int unsigned X    = 2,
  parameter              ID   = "LANE"
) (
  input  logic          clk,
  input  logic          rst,
`ifdef PROJ_LANE_ERRINJ_EN
  input  logic          errinj,
`endif
  output logic [EW-1:0] errcntr
);

  localparam int unsigned AW = $clog2(D);
  localparam int unsigned TW = (X > 1) ? $clog2(X) : 1;

  logic [W-1:0]  mem [D];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [W-1:0]  gencntr, expcntr, wdata, head;
  logic [TW-1:0] thr;
  logic          full, empty, wr, rd, tick, mism;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign tick = (thr == TW'(X - 1));
  assign wr   = !full;
  assign rd   = tick && !empty;
  assign mism = (head != expcntr);

`ifdef PROJ_LANE_ERRINJ_EN
  assign wdata = gencntr ^ {{(W-1){1'b0}}, errinj};
`else
  assign wdata = gencntr;
`endif

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      gencntr <= '0;
      expcntr <= '0;
      thr     <= '0;
      errcntr <= '0;
    end else begin
      if (wr) begin
        wr_ptr  <= wr_ptr + 1'b1;
        gencntr <= gencntr + 1'b1;
      end
      if (rd) begin
        rd_ptr  <= rd_ptr + 1'b1;
        expcntr <= expcntr + 1'b1;
        if (mism && (errcntr != {EW{1'b1}})) errcntr <= errcntr + 1'b1;
      end
      thr <= tick ? '0 : thr + 1'b1;
    end
  end

  if (EDBG != 0) begin : g_dbg
`ifndef SYNTHESIS
    always @(posedge clk) begin
      if (!rst && rd && mism) $display("%s t=%0t exp=%0h got=%0h", ID, $time, expcntr, head);
    end
`endif
  end

endmodule

// File: tb/tb_proj_lane.sv
// Bench for proj_lane: two lanes (defaults, and W=4/X=1/D=4/EW=2) against a cycle model.
// Compile with PROJ_LANE_ERRINJ_EN to also exercise error injection and saturation.
module tb_proj_lane;

  localparam int LW [2] = '{16, 4};
  localparam int LX [2] = '{2, 1};
  localparam int LD [2] = '{8, 4};
  localparam int LE [2] = '{255, 3};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inj [2];
  logic [7:0] err0;
  logic [1:0] err1;

  int checks = 0;
  int errors = 0;
  int mgen [2], mexp [2], mthr [2], mcnt [2], merr [2], pops [2];
  int q0 [$];
  int q1 [$];

  always #5 clk = ~clk;

  proj_lane #(.W(16), .EW(8), .D(8), .EDBG(0), .X(2), .ID("L0")) dut0 (
    .clk     (clk),
    .rst     (rst),
`ifdef PROJ_LANE_ERRINJ_EN
    .errinj  (inj[0]),
`endif
    .errcntr (err0)
  );

  proj_lane #(.W(4), .EW(2), .D(4), .EDBG(0), .X(1), .ID("L1")) dut1 (
    .clk     (clk),
    .rst     (rst),
`ifdef PROJ_LANE_ERRINJ_EN
    .errinj  (inj[1]),
`endif
    .errcntr (err1)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int obs(input int l, input int sel);
    case (sel)
      0:       return l == 0 ? int'(dut0.wr)    : int'(dut1.wr);
      1:       return l == 0 ? int'(dut0.rd)    : int'(dut1.rd);
      2:       return l == 0 ? int'(dut0.head)  : int'(dut1.head);
      3:       return l == 0 ? int'(err0)       : int'(err1);
      4:       return l == 0 ? int'(dut0.full)  : int'(dut1.full);
      default: return l == 0 ? int'(dut0.empty) : int'(dut1.empty);
    endcase
  endfunction

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      mgen[l] = 0; mexp[l] = 0; mthr[l] = 0; mcnt[l] = 0; merr[l] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Negedge: compare DUT state with the model, then advance the model by one posedge.
  always @(negedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      for (int l = 0; l < 2; l++) begin
        int mwr, mrd, tick, f, mask;
        mask = (1 << LW[l]) - 1;
        mwr  = (mcnt[l] < LD[l]) ? 1 : 0;
        tick = (mthr[l] == LX[l] - 1) ? 1 : 0;
        mrd  = (tick != 0 && mcnt[l] > 0) ? 1 : 0;
        check($sformatf("wr%0d", l), obs(l, 0), mwr);
        check($sformatf("rd%0d", l), obs(l, 1), mrd);
        check($sformatf("full%0d", l), obs(l, 4), (mcnt[l] == LD[l]) ? 1 : 0);
        check($sformatf("errcntr%0d", l), obs(l, 3), merr[l]);
        if (mrd != 0) begin
          f = (l == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("data%0d", l), obs(l, 2), f);
          pops[l]++;
          if (f != mexp[l] && merr[l] < LE[l]) merr[l]++;
          mexp[l] = (mexp[l] + 1) & mask;
        end
        if (mwr != 0) begin
          f = mgen[l] ^ (inj[l] ? 1 : 0);
          if (l == 0) q0.push_back(f);
          else q1.push_back(f);
          mgen[l] = (mgen[l] + 1) & mask;
        end
        mthr[l] = (tick != 0) ? 0 : mthr[l] + 1;
        mcnt[l] = mcnt[l] + mwr - mrd;
      end
    end
  end

  initial begin
    bit hit;
    inj[0] = 1'b0;
    inj[1] = 1'b0;
    pops[0] = 0;
    pops[1] = 0;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check("rst_err0", int'(err0), 0);
    check("rst_empty0", int'(dut0.empty), 1);
    check("rst_gen0", int'(dut0.gencntr), 0);
    #1 rst = 1'b0;

    // Mid-run asynchronous reset with lane 0 half full.
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk);
      #2;
      if (mcnt[0] == 4) hit = 1'b1;
    end
    check("halffull_reached", int'(hit), 1);
    check("halffull_cnt0", obs(0, 5), 0);
    #1 rst = 1'b1;
    #1;
    check("async_err0", int'(err0), 0);
    check("async_err1", int'(err1), 0);
    check("async_empty0", int'(dut0.empty), 1);
    check("async_empty1", int'(dut1.empty), 1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

`ifdef PROJ_LANE_ERRINJ_EN
    // Single corrupted word of value 5 on lane 0.
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(posedge clk);
      #2;
      if (mgen[0] == 5 && mcnt[0] < LD[0]) begin
        inj[0] = 1'b1;
        @(posedge clk);
        #2 inj[0] = 1'b0;
        hit = 1'b1;
      end
    end
    check("inj_hit", int'(hit), 1);
    // Lane 1: ten corrupted writes saturate the 2-bit counter.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2;
      inj[1] = (mcnt[1] < LD[1]) ? 1'b1 : 1'b0;
      if (mcnt[1] >= LD[1]) i--;
    end
    @(posedge clk);
    #2 inj[1] = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("inj_err0", int'(err0), 1);
    check("sat_err1", int'(err1), 3);
    rst = 1'b1;
    #1;
    check("rst2_err1", int'(err1), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
`endif

    pops[0] = 0;
    pops[1] = 0;
    repeat (1000) @(posedge clk);
    #1;
    // X=2 lane pops every other cycle; X=1 lane wraps its 4-bit count many times.
    check("pops0", int'(pops[0] > 450), 1);
    check("pops1", int'(pops[1] > 900), 1);
    check("final_err0", int'(err0), 0);
    check("final_err1", int'(err1), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
